// File: rtl/gyro_spi_sequencer.sv
// L3G4200D gyro sequencer: configures CTRL_REG1, then polls X/Y/Z over a byte SPI engine.
// Optional WHO_AMI check before init is enabled by defining GYRO_WHOAMI_CHECK_EN.
module gyro_spi_sequencer #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned CS_GAP     = 8,
  parameter logic [7:0]  CTRL1_VAL  = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        tx_begin,
  output logic [7:0]  tx_data,
  input  logic [7:0]  rx_data,
  input  logic        tx_end,
  output logic        cs,
  output logic [15:0] data_x,
  output logic [15:0] data_y,
  output logic [15:0] data_z,
  output logic        data_valid,
  output logic        busy,
  output logic        err
);

  localparam int unsigned WW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(SAMPLE_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [3:0] {
    S_RST_GAP,
    S_INIT_ADDR,
    S_INIT_DATA,
    S_INIT_GAP,
    S_WAIT,
    S_RD_ADDR,
    S_RD_BYTE,
    S_UPDATE,
    S_RD_GAP
`ifdef GYRO_WHOAMI_CHECK_EN
    , S_WHO_ADDR,
    S_WHO_DATA,
    S_WHO_GAP,
    S_WHO_WAIT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            cs_q, cs_d;
  logic            tx_begin_q, tx_begin_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            pend_q, pend_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [15:0]     data_x_q, data_x_d;
  logic [15:0]     data_y_q, data_y_d;
  logic [15:0]     data_z_q, data_z_d;
  logic            data_valid_q, data_valid_d;
  logic            is_send;
  logic [7:0]      send_byte;
  logic            done;
  logic            gap_last;
  logic            wait_last;

`ifdef GYRO_WHOAMI_CHECK_EN
  logic [7:0]      who_q, who_d;
  logic            err_q, err_d;
`endif

  assign gap_last  = (gap_q == GAP_LAST);
  assign wait_last = (wait_q == WAIT_LAST);
  // pend_q is only ever set from a send state, so done cannot fire on a stray tx_end
  assign done      = pend_q & tx_end;

  always_comb begin
    is_send   = 1'b0;
    send_byte = 8'h00;
    case (state_q)
      S_INIT_ADDR: begin is_send = 1'b1; send_byte = 8'h20;     end
      S_INIT_DATA: begin is_send = 1'b1; send_byte = CTRL1_VAL; end
      S_RD_ADDR:   begin is_send = 1'b1; send_byte = 8'hE8;     end
      S_RD_BYTE:   begin is_send = 1'b1; send_byte = 8'h00;     end
`ifdef GYRO_WHOAMI_CHECK_EN
      S_WHO_ADDR:  begin is_send = 1'b1; send_byte = 8'h8F;     end
      S_WHO_DATA:  begin is_send = 1'b1; send_byte = 8'h00;     end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cs_d         = cs_q;
    tx_begin_d   = 1'b0;
    tx_data_d    = tx_data_q;
    pend_d       = pend_q;
    gap_d        = gap_q;
    wait_d       = wait_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    data_x_d     = data_x_q;
    data_y_d     = data_y_q;
    data_z_d     = data_z_q;
    data_valid_d = 1'b0;
`ifdef GYRO_WHOAMI_CHECK_EN
    who_d        = who_q;
    err_d        = err_q;
`endif

    if (is_send) begin
      if (!pend_q) begin
        tx_begin_d = 1'b1;
        tx_data_d  = send_byte;
        pend_d     = 1'b1;
      end else if (tx_end) begin
        pend_d = 1'b0;
      end
    end

    case (state_q)
      S_RST_GAP: begin
        if (gap_last) begin
          gap_d = '0;
          cs_d  = 1'b0;
`ifdef GYRO_WHOAMI_CHECK_EN
          state_d = S_WHO_ADDR;
`else
          state_d = S_INIT_ADDR;
`endif
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_INIT_ADDR: if (done) state_d = S_INIT_DATA;
      S_INIT_DATA: begin
        if (done) begin
          cs_d    = 1'b1;
          state_d = S_INIT_GAP;
        end
      end
      S_INIT_GAP, S_RD_GAP: begin
        if (gap_last) begin
          gap_d   = '0;
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_WAIT: begin
        if (!wait_last) begin
          wait_d = wait_q + WW'(1);
        end else if (enable) begin
          wait_d  = '0;
          cs_d    = 1'b0;
          state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (done) begin
          idx_d   = '0;
          state_d = S_RD_BYTE;
        end
      end
      S_RD_BYTE: begin
        if (done) begin
          shadow_d[idx_q] = rx_data;
          if (idx_q == 3'd5) begin
            // commit on the final tx_end so the new words are visible during UPDATE
            data_x_d     = {shadow_q[1], shadow_q[0]};
            data_y_d     = {shadow_q[3], shadow_q[2]};
            data_z_d     = {rx_data, shadow_q[4]};
            data_valid_d = 1'b1;
            cs_d         = 1'b1;
            state_d      = S_UPDATE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_UPDATE: begin
        gap_d   = '0;
        state_d = S_RD_GAP;
      end
`ifdef GYRO_WHOAMI_CHECK_EN
      S_WHO_ADDR: if (done) state_d = S_WHO_DATA;
      S_WHO_DATA: begin
        if (done) begin
          who_d   = rx_data;
          cs_d    = 1'b1;
          state_d = S_WHO_GAP;
        end
      end
      S_WHO_GAP: begin
        if (gap_last) begin
          gap_d = '0;
          if (who_q == 8'hD3) begin
            cs_d    = 1'b0;
            state_d = S_INIT_ADDR;
          end else begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = S_WHO_WAIT;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_WHO_WAIT: begin
        if (wait_last) begin
          wait_d  = '0;
          cs_d    = 1'b0;
          state_d = S_WHO_ADDR;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
`endif
      default: state_d = S_RST_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RST_GAP;
      cs_q         <= 1'b1;
      tx_begin_q   <= 1'b0;
      tx_data_q    <= '0;
      pend_q       <= 1'b0;
      gap_q        <= '0;
      wait_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      data_x_q     <= '0;
      data_y_q     <= '0;
      data_z_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      tx_begin_q   <= tx_begin_d;
      tx_data_q    <= tx_data_d;
      pend_q       <= pend_d;
      gap_q        <= gap_d;
      wait_q       <= wait_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      data_x_q     <= data_x_d;
      data_y_q     <= data_y_d;
      data_z_q     <= data_z_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef GYRO_WHOAMI_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      who_q <= '0;
      err_q <= 1'b0;
    end else begin
      who_q <= who_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cs         = cs_q;
  assign tx_begin   = tx_begin_q;
  assign tx_data    = tx_data_q;
  assign data_x     = data_x_q;
  assign data_y     = data_y_q;
  assign data_z     = data_z_q;
  assign data_valid = data_valid_q;
  assign busy       = ~cs_q | pend_q;

endmodule

// File: doc/gyro_spi_sequencer.md
Name: gyro_spi_sequencer

Overview:
Controller that sequences the SPI byte engine to configure the Pmod gyro (L3G4200D) and poll its X/Y/Z rate registers. It issues one byte at a time over the tx_begin/tx_end handshake, drives chip select, and assembles the little-endian axis words. It sits between the top-level display/consumer logic and the SPI byte engine.

Parameters:
SAMPLE_DIV, 100000, clk cycles spent in WAIT between read bursts (1 kHz at 100 MHz); minimum 1
CS_GAP, 8, clk cycles cs is held high between transactions; minimum 1
CTRL1_VAL, 8'h0F, value written to CTRL_REG1 (0x20) at init: normal mode, all axes enabled

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  1 = polling permitted; 0 = stop after the current transaction
tx_begin  out  1  one-cycle pulse; SPI engine starts shifting tx_data
tx_data  out  8  byte to send; stable from the tx_begin cycle until tx_end
rx_data  in  8  byte received; valid in the cycle tx_end is high
tx_end  in  1  one-cycle pulse from the SPI engine: byte complete
cs  out  1  gyro chip select, active low
data_x  out  16  last committed X rate, two's complement
data_y  out  16  last committed Y rate
data_z  out  16  last committed Z rate
data_valid  out  1  one-cycle pulse when data_x/y/z update
busy  out  1  1 while cs is low or a tx is outstanding
err  out  1  WHO_AM_I mismatch, sticky (GYRO_WHOAMI_CHECK_EN only; else tied 0)

Behaviour:
- Reset (rst=0, async): state RST_GAP, cs=1, tx_begin=0, tx_data=0, data_x/y/z=0, data_valid=0, busy=0, err=0, all counters and shadow registers 0. Reset mid-transaction drops cs immediately; the SPI engine's pending tx_end is ignored.
- Byte send primitive: in the send cycle, tx_begin=1 and tx_data=byte. Then wait with tx_begin=0 until tx_end=1. At most one byte in flight. tx_end arriving while nothing is outstanding is ignored. rx_data is captured only in the tx_end cycle.
- States:
  - RST_GAP: cs=1 for CS_GAP cycles, then INIT_ADDR.
  - INIT_ADDR: cs=0; send 8'h20.
  - INIT_DATA: send CTRL1_VAL.
  - INIT_GAP: cs=1 for CS_GAP cycles.
  - WAIT: cs=1; count SAMPLE_DIV cycles. At terminal count, go to RD_ADDR if enable=1; otherwise hold the count at terminal.
  - RD_ADDR: cs=0; send 8'hE8 (read | auto-increment | 0x28).
  - RD_BYTE: six sends of 8'h00. Captured bytes go in order to xl, xh, yl, yh, zl, zh shadow registers. A 3-bit index counts 0..5.
  - UPDATE: one cycle. cs=1; data_x={xh,xl}, data_y={yh,yl}, data_z={zh,zl} commit in the same cycle; data_valid=1. Then RD_GAP.
  - RD_GAP: cs=1 for CS_GAP cycles, then WAIT (counter restarts at 0).
- cs falls one cycle before the first tx_begin of a transaction. cs rises in the cycle after the last tx_end.
- enable=0 mid-burst: the burst completes and UPDATE occurs; enable is sampled only at the WAIT terminal count.
- Outputs never show a partial burst; they change only in UPDATE.
- busy = (cs==0) | tx outstanding.

Optional Feature:
- Macro: GYRO_WHOAMI_CHECK_EN.
- Defined: after RST_GAP, run a WHOAMI transaction: send 8'h8F, then 8'h00. Capture the byte and apply CS_GAP.
  - Byte == 8'hD3: proceed to INIT_ADDR.
  - Otherwise: set err=1 (sticky until reset) and retry WHOAMI after a full SAMPLE_DIV wait.
- Undefined: no WHOAMI state; err tied 0; RST_GAP goes directly to INIT_ADDR.

Test Plan:
1. Release rst; SPI model returns tx_end 16 cycles after each tx_begin. Required: first two tx_data are 8'h20, 8'h0F under one cs-low window; cs high ≥8 cycles afterwards.
2. SAMPLE_DIV=50; model returns 34,12,78,56,BC,9A on the six read bytes. Required: tx_data 8'hE8 then six 8'h00; data_x=16'h1234, data_y=16'h5678, data_z=16'h9ABC; data_valid is a single pulse in the cycle cs rises.
3. Model returns FF,FF,00,80,01,00. Required: data_x=16'hFFFF, data_y=16'h8000, data_z=16'h0001, all committed together; no intermediate output change.
4. Drop enable during the third RD_BYTE. Required: the burst completes and data_valid pulses once, then no further tx_begin. Re-raise enable: next RD_ADDR starts at the WAIT terminal count.
5. Assert rst during RD_BYTE index 2. Required: cs=1 and data_x/y/z=0 asynchronously; after release, the sequence restarts with 8'h20.
6. With GYRO_WHOAMI_CHECK_EN: model returns 8'hD2. Required: err=1 and no 8'h20 sent. With model returning 8'hD3 after reset: err stays 0 and 8'h20 follows the WHOAMI gap.
